// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, done/frame-error strobes.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point.
module uart_rx #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int data_len     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_serial,
  output logic [data_len-1:0] rx_data,
  output logic                rx_done,
  output logic                rx_busy,
  output logic                frame_err
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BW  = (data_len > 1) ? $clog2(data_len) : 1;
  localparam int MID = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] BIT_LIM = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(data_len - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       clk_count, clk_count_n;
  logic [BW-1:0]       bit_count, bit_count_n;
  logic [data_len-1:0] shift_reg, shift_n, data_n;
  logic                done_n, err_n;
  logic                sync1, rx_s, sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_serial;
      rx_s  <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one cycle after the nominal sample point, so the vote sees
  // the line one cycle before, at, and after it.
  localparam logic [CW-1:0] START_LIM = CW'(MID + 1);
  logic hist1, hist2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist1 <= 1'b1;
      hist2 <= 1'b1;
    end else begin
      hist1 <= rx_s;
      hist2 <= hist1;
    end
  end

  assign sample = (hist2 & hist1) | (hist2 & rx_s) | (hist1 & rx_s);
`else
  localparam logic [CW-1:0] START_LIM = CW'(MID);
  assign sample = rx_s;
`endif

  assign rx_busy = (state == START) || (state == DATA) || (state == STOP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clk_count <= '0;
      bit_count <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      clk_count <= clk_count_n;
      bit_count <= bit_count_n;
      shift_reg <= shift_n;
      rx_data   <= data_n;
      rx_done   <= done_n;
      frame_err <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    clk_count_n = clk_count;
    bit_count_n = bit_count;
    shift_n     = shift_reg;
    data_n      = rx_data;
    done_n      = 1'b0;
    err_n       = 1'b0;
    case (state)
      IDLE: begin
        clk_count_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (clk_count == START_LIM) begin
          clk_count_n = '0;
          bit_count_n = '0;
          state_n     = sample ? IDLE : DATA;
        end else begin
          clk_count_n = clk_count + 1'b1;
        end
      end
      DATA: begin
        if (clk_count == BIT_LIM) begin
          clk_count_n         = '0;
          shift_n[bit_count]  = sample;
          if (bit_count == LAST_BIT) state_n = STOP;
          else bit_count_n = bit_count + 1'b1;
        end else begin
          clk_count_n = clk_count + 1'b1;
        end
      end
      STOP: begin
        if (clk_count == BIT_LIM) begin
          clk_count_n = '0;
          if (sample) begin
            data_n  = shift_reg;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          clk_count_n = clk_count + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must rise before a new start edge counts.
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n     = IDLE;
        clk_count_n = '0;
        bit_count_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at CLKS_PER_BIT=16.
// Honours UART_RX_MAJORITY_EN for the sample-point glitch frame.
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int MID = (CPB - 1) / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, frame_err;

  uart_rx #(.CLKS_PER_BIT(CPB), .data_len(8)) dut (
    .clk(clk), .reset(reset), .rx_serial(rx_serial), .rx_data(rx_data),
    .rx_done(rx_done), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   cycle = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_done && frame_err) chk("done_and_err_together", 1, 0);
      if (rx_done) done_cyc.push_back(cycle);
      if (rx_done || frame_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", int'({rx_done, frame_err}), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("strobe_kind_is_err", int'(frame_err), int'(e.err));
          chk("rx_data", int'(rx_data), int'(e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) tick();
  endtask

  // Glitch inverts the line for one cycle at each bit's nominal sample slot.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic glitch_start, input logic glitch_rest);
    logic [9:0] bits;
    logic       v;
    bits = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        v = bits[b];
        if (c == MID + 1 && ((b == 0 && glitch_start) || (b > 0 && glitch_rest))) v = ~v;
        rx_serial = v;
        tick();
      end
    end
  endtask

  initial begin
    int busy_cnt;
    exp_t e;
    logic [7:0] d55;
    reset     = 1'b1;
    rx_serial = 1'b1;
    repeat (3) tick();
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_done", int'(rx_done), 0);
    chk("reset_rx_busy", int'(rx_busy), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    idle(10);

    e = '{1'b0, 8'hA5}; sb.push_back(e);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(20);
    chk("busy_after_a5", int'(rx_busy), 0);

    done_cyc.delete();
    e = '{1'b0, 8'h00}; sb.push_back(e);
    e = '{1'b0, 8'hFF}; sb.push_back(e);
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    idle(20);
    chk("b2b_done_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("b2b_spacing", done_cyc[1] - done_cyc[0], 10 * CPB);

    e = '{1'b1, 8'hFF}; sb.push_back(e);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    busy_cnt = 0;
    rx_serial = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rx_busy) busy_cnt++;
    end
    chk("busy_during_break", busy_cnt, 0);
    idle(20);
    chk("rx_data_kept_after_err", int'(rx_data), 8'hFF);

    busy_cnt = 0;
    rx_serial = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rx_busy) busy_cnt++;
    end
    rx_serial = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rx_busy) busy_cnt++;
    end
    chk("glitch_busy_seen", int'(busy_cnt > 0), 1);
    chk("glitch_busy_bounded", int'(busy_cnt <= MID + 3), 1);

    d55 = 8'h55;
    rx_serial = 1'b0;
    repeat (CPB) tick();
    for (int b = 0; b < 4; b++) begin
      rx_serial = d55[b];
      repeat (CPB) tick();
    end
    rx_serial = d55[4];
    repeat (CPB / 2) tick();
    chk("busy_before_reset", int'(rx_busy), 1);
    reset = 1'b1;
    #1;
    chk("midreset_rx_data", int'(rx_data), 0);
    chk("midreset_rx_busy", int'(rx_busy), 0);
    chk("midreset_strobes", int'({rx_done, frame_err}), 0);
    rx_serial = 1'b1;
    tick();
    reset = 1'b0;
    idle(20);
    e = '{1'b0, 8'h81}; sb.push_back(e);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle(20);

`ifdef UART_RX_MAJORITY_EN
    e = '{1'b0, 8'h96}; sb.push_back(e);
    send_frame(8'h96, 1'b1, 1'b1, 1'b1);
`else
    // Single sampling sees every data bit and the stop bit inverted.
    e = '{1'b1, 8'h81}; sb.push_back(e);
    send_frame(8'h96, 1'b1, 1'b0, 1'b1);
`endif
    idle(30);
    chk("glitch_frame_rx_data", int'(rx_data),
`ifdef UART_RX_MAJORITY_EN
        8'h96
`else
        8'h81
`endif
    );
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
